// File: rtl/organ_note_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : organ_note_sequencer
// Brief    : Note word / tone gate source for the organ clock divider,
//            manual switch selection or auto ascending scale.
// Revision : 1.0
// ============================================================================
module organ_note_sequencer #(
    parameter int unsigned NOTE_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000
) (
    input  logic        inclk,
    input  logic        Reset,
    input  logic [2:0]  sw_note,
    input  logic        mode_auto,
    input  logic        play_en,
    output logic [31:0] div_clk_count,
    output logic [2:0]  note_idx,
    output logic        tone_on,
    output logic        note_strobe
);

    localparam logic [31:0] C_NOTE_LAST = 32'(NOTE_CYCLES - 1);
    localparam logic [31:0] C_GAP_LAST  = 32'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NOTE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Divide words N = round(25e6/f) - 1 for Do523 .. Do'1047
    function automatic logic [31:0] note_word(input logic [2:0] idx);
        logic [31:0] w;
        case (idx)
            3'd0:    w = 32'd47800;
            3'd1:    w = 32'd42588;
            3'd2:    w = 32'd37935;
            3'd3:    w = 32'd35816;
            3'd4:    w = 32'd31887;
            3'd5:    w = 32'd28408;
            3'd6:    w = 32'd25303;
            default: w = 32'd23877;
        endcase
        return w;
    endfunction

    // {play_en, mode_auto, sw_note} through a two-stage synchronizer
    logic [4:0]  sync1_q, sync2_q;
    logic        en_s, auto_s;
    logic [2:0]  sw_s;

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [31:0] dur_q, dur_d;
    logic [31:0] count_q, count_d;
    logic [2:0]  idx_q, idx_d;
    logic        tone_q, tone_d;
    logic        strobe_q, strobe_d;

    assign en_s   = sync2_q[4];
    assign auto_s = sync2_q[3];
    assign sw_s   = sync2_q[2:0];

    always_ff @(posedge inclk) begin
        if (Reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            dur_q    <= '0;
            count_q  <= 32'd47800;
            idx_q    <= 3'd0;
            tone_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sync1_q  <= {play_en, mode_auto, sw_note};
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            mode_q   <= mode_d;
            dur_q    <= dur_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            tone_q   <= tone_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        dur_d    = dur_q;
        count_d  = count_q;
        idx_d    = idx_q;
        tone_d   = tone_q;
        strobe_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                tone_d = 1'b0;
                if (en_s) begin
                    state_d  = S_NOTE;
                    mode_d   = auto_s;
                    dur_d    = '0;
                    idx_d    = auto_s ? 3'd0 : sw_s;
                    count_d  = note_word(auto_s ? 3'd0 : sw_s);
                    tone_d   = 1'b1;
                    strobe_d = 1'b1;
                end
            end
            S_NOTE, S_GAP: begin
                // mode_q is the mode latched at start; a change aborts the run
                if (!en_s || (auto_s != mode_q)) begin
                    state_d = S_IDLE;
                    dur_d   = '0;
                    tone_d  = 1'b0;
                end else if (state_q == S_NOTE) begin
                    tone_d = 1'b1;
                    if (!mode_q) begin
                        if (sw_s != idx_q) begin
                            idx_d    = sw_s;
                            count_d  = note_word(sw_s);
                            strobe_d = 1'b1;
                        end
                    end else if (dur_q == C_NOTE_LAST) begin
                        state_d = S_GAP;
                        dur_d   = '0;
                        tone_d  = 1'b0;
                    end else begin
                        dur_d = dur_q + 32'd1;
                    end
                end else begin
                    tone_d = 1'b0;
                    if (dur_q == C_GAP_LAST) begin
                        state_d  = S_NOTE;
                        dur_d    = '0;
                        idx_d    = idx_q + 3'd1;
                        count_d  = note_word(idx_q + 3'd1);
                        tone_d   = 1'b1;
                        strobe_d = 1'b1;
                    end else begin
                        dur_d = dur_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                dur_d   = '0;
                tone_d  = 1'b0;
            end
        endcase
    end

    assign div_clk_count = count_q;
    assign note_idx      = idx_q;
    assign tone_on       = tone_q;
    assign note_strobe   = strobe_q;

endmodule
`default_nettype wire
